// File: rtl/wb_port_ctrl.sv
// Write-back port controller: merges a fixed-priority single-cycle ALU result
// stream with a 2-entry queued multi-cycle result stream onto the register
// file's single write port, and forwards not-yet-committed values to decode.
module wb_port_ctrl #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_a_valid,
  input  logic [4:0]      i_a_rd,
  input  logic [XLEN-1:0] i_a_data,
  input  logic            i_b_valid,
  output logic            o_b_ready,
  input  logic [4:0]      i_b_rd,
  input  logic [XLEN-1:0] i_b_data,
  output logic            o_Wen,
  output logic [4:0]      o_Wnum,
  output logic [XLEN-1:0] o_Wd,
  input  logic [4:0]      i_rnum1,
  input  logic [4:0]      i_rnum2,
  output logic            o_fwd1_hit,
  output logic            o_fwd2_hit,
  output logic [XLEN-1:0] o_fwd1_data,
  output logic [XLEN-1:0] o_fwd2_data,
  output logic            o_busy
);

  // FIFO storage: slot 0 is always the head, slot 1 the newer entry.
  logic [1:0]      count_q, count_d;
  logic [1:0]      live_q, live_d;
  logic [4:0]      rd_q   [2];
  logic [4:0]      rd_d   [2];
  logic [XLEN-1:0] data_q [2];
  logic [XLEN-1:0] data_d [2];

  logic            wen_q, wen_d;
  logic [4:0]      wnum_q, wnum_d;
  logic [XLEN-1:0] wd_q, wd_d;

  logic [1:0] vmask;
  logic       a_act;
  logic       b_enq;

  assign vmask     = {count_q == 2'd2, count_q != 2'd0};
  assign a_act     = i_a_valid && (i_a_rd != 5'd0);
  // Ready depends on registered occupancy only, so a pop never opens it early.
  assign o_b_ready = (count_q < 2'(DEPTH));
  assign b_enq     = i_b_valid && o_b_ready && (i_b_rd != 5'd0);

  assign o_Wen  = wen_q;
  assign o_Wnum = wnum_q;
  assign o_Wd   = wd_q;
  assign o_busy = (count_q != 2'd0) || wen_q;

  // Next-state: kill older same-rd entries, select the port source, pop/shift, enqueue.
  always_comb begin
    logic [1:0] live_k;
    logic [1:0] cnt_after;
    logic       idx;
    logic       pop;
    wen_d     = 1'b0;
    wnum_d    = wnum_q;
    wd_d      = wd_q;
    rd_d      = rd_q;
    data_d    = data_q;
    cnt_after = count_q;
    idx       = 1'b0;
    for (int i = 0; i < 2; i++) begin
      live_k[i] = live_q[i] & ~(a_act & vmask[i] & (rd_q[i] == i_a_rd));
    end
    live_d = live_k;
    // A dead head is dropped even while A owns the port; a live head waits for A to go idle.
    pop = vmask[0] && (!live_q[0] || !a_act);

    if (a_act) begin
      wen_d  = 1'b1;
      wnum_d = i_a_rd;
      wd_d   = i_a_data;
    end else if (vmask[0] && live_q[0]) begin
      wen_d  = 1'b1;
      wnum_d = rd_q[0];
      wd_d   = data_q[0];
    end

    if (pop) begin
      rd_d[0]   = rd_q[1];
      data_d[0] = data_q[1];
      live_d[0] = live_k[1];
      live_d[1] = 1'b0;
      cnt_after = count_q - 2'd1;
    end

    // The enqueued entry is newer than any same-edge A write, so it is never killed.
    if (b_enq) begin
      idx         = cnt_after[0];
      rd_d[idx]   = i_b_rd;
      data_d[idx] = i_b_data;
      live_d[idx] = 1'b1;
    end
    count_d = cnt_after + {1'b0, b_enq};
  end

  // Control state and write-port registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q <= 2'd0;
      live_q  <= 2'b00;
      wen_q   <= 1'b0;
      wnum_q  <= 5'd0;
      wd_q    <= '0;
    end else begin
      count_q <= count_d;
      live_q  <= live_d;
      wen_q   <= wen_d;
      wnum_q  <= wnum_d;
      wd_q    <= wd_d;
    end
  end

  // FIFO payload; validity is tracked by count/live, so no reset is needed here.
  always_ff @(posedge i_clk) begin
    rd_q   <= rd_d;
    data_q <= data_d;
  end

  // Forwarding: newest live queued entry wins, then older, then the value on the port.
  always_comb begin
    logic [4:0]      r    [2];
    logic            hit  [2];
    logic [XLEN-1:0] fdat [2];
    r[0] = i_rnum1;
    r[1] = i_rnum2;
    for (int p = 0; p < 2; p++) begin
      hit[p]  = 1'b0;
      fdat[p] = '0;
      if (r[p] != 5'd0) begin
        if (vmask[1] && live_q[1] && (rd_q[1] == r[p])) begin
          hit[p]  = 1'b1;
          fdat[p] = data_q[1];
        end else if (vmask[0] && live_q[0] && (rd_q[0] == r[p])) begin
          hit[p]  = 1'b1;
          fdat[p] = data_q[0];
        end else if (wen_q && (wnum_q == r[p])) begin
          hit[p]  = 1'b1;
          fdat[p] = wd_q;
        end
      end
    end
    o_fwd1_hit  = hit[0];
    o_fwd1_data = fdat[0];
    o_fwd2_hit  = hit[1];
    o_fwd2_data = fdat[1];
  end

endmodule

// File: tb/tb_wb_port_ctrl.sv
// Directed testbench for wb_port_ctrl.
module tb_wb_port_ctrl;
  localparam int XLEN = 32;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            i_a_valid;
  logic [4:0]      i_a_rd;
  logic [XLEN-1:0] i_a_data;
  logic            i_b_valid;
  logic            o_b_ready;
  logic [4:0]      i_b_rd;
  logic [XLEN-1:0] i_b_data;
  logic            o_Wen;
  logic [4:0]      o_Wnum;
  logic [XLEN-1:0] o_Wd;
  logic [4:0]      i_rnum1, i_rnum2;
  logic            o_fwd1_hit, o_fwd2_hit;
  logic [XLEN-1:0] o_fwd1_data, o_fwd2_data;
  logic            o_busy;

  int checks = 0;
  int fails  = 0;

  wb_port_ctrl #(.XLEN(XLEN), .DEPTH(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_a_valid(i_a_valid), .i_a_rd(i_a_rd), .i_a_data(i_a_data),
    .i_b_valid(i_b_valid), .o_b_ready(o_b_ready), .i_b_rd(i_b_rd), .i_b_data(i_b_data),
    .o_Wen(o_Wen), .o_Wnum(o_Wnum), .o_Wd(o_Wd),
    .i_rnum1(i_rnum1), .i_rnum2(i_rnum2),
    .o_fwd1_hit(o_fwd1_hit), .o_fwd2_hit(o_fwd2_hit),
    .o_fwd1_data(o_fwd1_data), .o_fwd2_data(o_fwd2_data),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic [4:0] rd, input logic [XLEN-1:0] d);
    i_a_valid = v; i_a_rd = rd; i_a_data = d;
  endtask

  task automatic set_b(input logic v, input logic [4:0] rd, input logic [XLEN-1:0] d);
    i_b_valid = v; i_b_rd = rd; i_b_data = d;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    tick(); tick();
    i_rst = 1'b0;
    #1;
    checks++; if (o_Wen !== 1'b0) begin fails++; $display("FAIL reset_wen: got %b expected 0", o_Wen); end
    checks++; if (o_Wnum !== 5'd0) begin fails++; $display("FAIL reset_wnum: got %0d expected 0", o_Wnum); end
    checks++; if (o_Wd !== 32'h0) begin fails++; $display("FAIL reset_wd: got %h expected 0", o_Wd); end
    checks++; if (o_b_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", o_b_ready); end
    checks++; if (o_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    i_rnum1 = 5'd5;
    #1;
    checks++; if (o_fwd1_hit !== 1'b0) begin fails++; $display("FAIL reset_fwd_hit: got %b expected 0", o_fwd1_hit); end
    checks++; if (o_fwd1_data !== 32'h0) begin fails++; $display("FAIL reset_fwd_data: got %h expected 0", o_fwd1_data); end
    tick();
    checks++; if (o_Wen !== 1'b0) begin fails++; $display("FAIL idle_wen: got %b expected 0", o_Wen); end
  endtask

  task automatic test_a_only();
    set_a(1'b1, 5'd3, 32'h33);
    tick();
    set_a(1'b0, 5'd0, 32'h0);
    i_rnum1 = 5'd3;
    #1;
    checks++; if (o_Wen !== 1'b1) begin fails++; $display("FAIL a_wen: got %b expected 1", o_Wen); end
    checks++; if (o_Wnum !== 5'd3) begin fails++; $display("FAIL a_wnum: got %0d expected 3", o_Wnum); end
    checks++; if (o_Wd !== 32'h33) begin fails++; $display("FAIL a_wd: got %h expected 33", o_Wd); end
    checks++; if (o_busy !== 1'b1) begin fails++; $display("FAIL a_busy: got %b expected 1", o_busy); end
    checks++; if (o_fwd1_hit !== 1'b1) begin fails++; $display("FAIL a_fwd_hit: got %b expected 1", o_fwd1_hit); end
    checks++; if (o_fwd1_data !== 32'h33) begin fails++; $display("FAIL a_fwd_data: got %h expected 33", o_fwd1_data); end
    tick();
    checks++; if (o_Wen !== 1'b0) begin fails++; $display("FAIL a_one_cycle: got %b expected 0", o_Wen); end
    checks++; if (o_busy !== 1'b0) begin fails++; $display("FAIL a_idle_busy: got %b expected 0", o_busy); end
    checks++; if (o_fwd1_hit !== 1'b0) begin fails++; $display("FAIL a_fwd_after: got %b expected 0", o_fwd1_hit); end
  endtask

  task automatic test_priority();
    set_a(1'b1, 5'd1, 32'h11); set_b(1'b1, 5'd7, 32'h77);
    tick();
    checks++; if (o_Wnum !== 5'd1 || o_Wen !== 1'b1) begin fails++; $display("FAIL pri_w1: got wen=%b num=%0d expected wen=1 num=1", o_Wen, o_Wnum); end
    checks++; if (o_b_ready !== 1'b1) begin fails++; $display("FAIL pri_ready1: got %b expected 1", o_b_ready); end
    set_a(1'b1, 5'd2, 32'h22); set_b(1'b1, 5'd8, 32'h88);
    tick();
    checks++; if (o_Wnum !== 5'd2 || o_Wd !== 32'h22) begin fails++; $display("FAIL pri_w2: got num=%0d d=%h expected num=2 d=22", o_Wnum, o_Wd); end
    checks++; if (o_b_ready !== 1'b0) begin fails++; $display("FAIL pri_full: got %b expected 0", o_b_ready); end
    set_a(1'b1, 5'd4, 32'h44); set_b(1'b1, 5'd10, 32'hA0);
    i_rnum2 = 5'd8;
    #1;
    checks++; if (o_fwd2_hit !== 1'b1 || o_fwd2_data !== 32'h88) begin fails++; $display("FAIL pri_fwd8: got hit=%b d=%h expected hit=1 d=88", o_fwd2_hit, o_fwd2_data); end
    tick();
    checks++; if (o_Wnum !== 5'd4 || o_Wd !== 32'h44) begin fails++; $display("FAIL pri_w4: got num=%0d d=%h expected num=4 d=44", o_Wnum, o_Wd); end
    checks++; if (o_b_ready !== 1'b0) begin fails++; $display("FAIL pri_held: got %b expected 0", o_b_ready); end
    set_a(1'b0, 5'd0, 32'h0);
    tick();
    checks++; if (o_Wen !== 1'b1 || o_Wnum !== 5'd7 || o_Wd !== 32'h77) begin fails++; $display("FAIL pri_w7: got wen=%b num=%0d d=%h expected 1/7/77", o_Wen, o_Wnum, o_Wd); end
    checks++; if (o_b_ready !== 1'b1) begin fails++; $display("FAIL pri_ready_again: got %b expected 1", o_b_ready); end
    tick();
    set_b(1'b0, 5'd0, 32'h0);
    checks++; if (o_Wen !== 1'b1 || o_Wnum !== 5'd8 || o_Wd !== 32'h88) begin fails++; $display("FAIL pri_w8: got wen=%b num=%0d d=%h expected 1/8/88", o_Wen, o_Wnum, o_Wd); end
    tick();
    checks++; if (o_Wen !== 1'b1 || o_Wnum !== 5'd10 || o_Wd !== 32'hA0) begin fails++; $display("FAIL pri_w10: got wen=%b num=%0d d=%h expected 1/10/a0", o_Wen, o_Wnum, o_Wd); end
    tick();
    checks++; if (o_Wen !== 1'b0 || o_busy !== 1'b0) begin fails++; $display("FAIL pri_drain: got wen=%b busy=%b expected 0/0", o_Wen, o_busy); end
  endtask

  task automatic test_kill();
    set_a(1'b1, 5'd1, 32'h11); set_b(1'b1, 5'd9, 32'h99);
    tick();
    set_b(1'b0, 5'd0, 32'h0);
    i_rnum1 = 5'd9;
    #1;
    checks++; if (o_fwd1_hit !== 1'b1 || o_fwd1_data !== 32'h99) begin fails++; $display("FAIL kill_fwd_q: got hit=%b d=%h expected 1/99", o_fwd1_hit, o_fwd1_data); end
    set_a(1'b1, 5'd9, 32'hAA);
    tick();
    set_a(1'b0, 5'd0, 32'h0);
    #1;
    checks++; if (o_Wen !== 1'b1 || o_Wnum !== 5'd9 || o_Wd !== 32'hAA) begin fails++; $display("FAIL kill_wAA: got wen=%b num=%0d d=%h expected 1/9/aa", o_Wen, o_Wnum, o_Wd); end
    checks++; if (o_fwd1_hit !== 1'b1 || o_fwd1_data !== 32'hAA) begin fails++; $display("FAIL kill_fwd: got hit=%b d=%h expected 1/aa", o_fwd1_hit, o_fwd1_data); end
    checks++; if (o_busy !== 1'b1) begin fails++; $display("FAIL kill_busy: got %b expected 1", o_busy); end
    tick();
    checks++; if (o_Wen !== 1'b0) begin fails++; $display("FAIL kill_no99: got wen=%b num=%0d d=%h expected wen=0", o_Wen, o_Wnum, o_Wd); end
    checks++; if (o_fwd1_hit !== 1'b0) begin fails++; $display("FAIL kill_fwd_clear: got %b expected 0", o_fwd1_hit); end
    tick();
    checks++; if (o_Wen !== 1'b0 || o_busy !== 1'b0) begin fails++; $display("FAIL kill_idle: got wen=%b busy=%b expected 0/0", o_Wen, o_busy); end
  endtask

  task automatic test_same_edge();
    set_a(1'b1, 5'd6, 32'h60); set_b(1'b1, 5'd6, 32'h61);
    tick();
    set_a(1'b0, 5'd0, 32'h0); set_b(1'b0, 5'd0, 32'h0);
    i_rnum1 = 5'd6;
    #1;
    checks++; if (o_Wnum !== 5'd6 || o_Wd !== 32'h60) begin fails++; $display("FAIL same_w1: got num=%0d d=%h expected 6/60", o_Wnum, o_Wd); end
    checks++; if (o_fwd1_hit !== 1'b1 || o_fwd1_data !== 32'h61) begin fails++; $display("FAIL same_fwd1: got hit=%b d=%h expected 1/61", o_fwd1_hit, o_fwd1_data); end
    tick();
    checks++; if (o_Wen !== 1'b1 || o_Wnum !== 5'd6 || o_Wd !== 32'h61) begin fails++; $display("FAIL same_w2: got wen=%b num=%0d d=%h expected 1/6/61", o_Wen, o_Wnum, o_Wd); end
    checks++; if (o_fwd1_data !== 32'h61) begin fails++; $display("FAIL same_fwd2: got %h expected 61", o_fwd1_data); end
    tick();
    checks++; if (o_Wen !== 1'b0) begin fails++; $display("FAIL same_end: got %b expected 0", o_Wen); end
  endtask

  task automatic test_x0();
    set_a(1'b1, 5'd0, 32'h5); set_b(1'b1, 5'd0, 32'h6);
    i_rnum1 = 5'd0;
    #1;
    checks++; if (o_b_ready !== 1'b1) begin fails++; $display("FAIL x0_ready: got %b expected 1", o_b_ready); end
    checks++; if (o_fwd1_hit !== 1'b0 || o_fwd1_data !== 32'h0) begin fails++; $display("FAIL x0_fwd: got hit=%b d=%h expected 0/0", o_fwd1_hit, o_fwd1_data); end
    tick();
    set_a(1'b0, 5'd0, 32'h0); set_b(1'b0, 5'd0, 32'h0);
    checks++; if (o_Wen !== 1'b0 || o_busy !== 1'b0) begin fails++; $display("FAIL x0_nowrite: got wen=%b busy=%b expected 0/0", o_Wen, o_busy); end
    tick();
    checks++; if (o_Wen !== 1'b0 || o_b_ready !== 1'b1) begin fails++; $display("FAIL x0_after: got wen=%b ready=%b expected 0/1", o_Wen, o_b_ready); end
  endtask

  task automatic test_reset_mid();
    set_a(1'b1, 5'd1, 32'h11); set_b(1'b1, 5'd11, 32'hB1);
    tick();
    set_a(1'b1, 5'd2, 32'h22); set_b(1'b1, 5'd12, 32'hB2);
    tick();
    set_a(1'b0, 5'd0, 32'h0); set_b(1'b0, 5'd0, 32'h0);
    checks++; if (o_b_ready !== 1'b0) begin fails++; $display("FAIL rst_full: got %b expected 0", o_b_ready); end
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    i_rnum1 = 5'd11; i_rnum2 = 5'd12;
    #1;
    checks++; if (o_Wen !== 1'b0 || o_busy !== 1'b0) begin fails++; $display("FAIL rst_clear: got wen=%b busy=%b expected 0/0", o_Wen, o_busy); end
    checks++; if (o_fwd1_hit !== 1'b0 || o_fwd2_hit !== 1'b0) begin fails++; $display("FAIL rst_fwd: got %b/%b expected 0/0", o_fwd1_hit, o_fwd2_hit); end
    checks++; if (o_b_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b expected 1", o_b_ready); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (o_Wen !== 1'b0 || o_busy !== 1'b0) begin fails++; $display("FAIL rst_post%0d: got wen=%b busy=%b expected 0/0", k, o_Wen, o_busy); end
    end
  endtask

  initial begin
    i_rst = 1'b1;
    set_a(1'b0, 5'd0, 32'h0);
    set_b(1'b0, 5'd0, 32'h0);
    i_rnum1 = 5'd0;
    i_rnum2 = 5'd0;
    test_reset();
    test_a_only();
    test_priority();
    test_kill();
    test_same_edge();
    test_x0();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
